// File: rtl/wb_ram_responder.sv
// wb_ram_responder: pipelined Wishbone responder over a word RAM with programmable wait states.
// One request in flight at a time; ack/err is a single-cycle pulse and read data is registered.
module wb_ram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hb000_0000,
  parameter int          DEPTH       = 16384,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic        o_wb_stall
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] W_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0]    cnt;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q, rd_q;
  logic [3:0]    sel_q;
  logic [31:0]   mem [DEPTH];
  logic          accept, ok_q;
  logic [AW-1:0] rd_idx;
  assign accept     = (state == IDLE) && i_wb_cyc && i_wb_stb;
  assign ok_q       = (addr_q[31:AW+2] == BASE_ADDR[31:AW+2]) && (addr_q[1:0] == 2'b00);
  assign o_wb_stall = (state != IDLE);
  assign o_wb_ack   = (state == RESP) && i_wb_cyc && ok_q;
  assign o_wb_err   = (state == RESP) && i_wb_cyc && !ok_q;
  assign o_wb_data  = (o_wb_ack && !we_q) ? rd_q : 32'd0;
  // With no wait states the RAM is read on the accepting edge, before addr_q is valid.
  assign rd_idx     = (state == IDLE) ? i_wb_addr[AW+1:2] : addr_q[AW+1:2];
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = accept ? ((WAIT_STATES == 0) ? RESP : WAIT) : IDLE;
    else if (!i_wb_cyc || state == RESP)
      state_nx = IDLE;
    else if (cnt == W_LAST)
      state_nx = RESP;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      sel_q   <= 4'd0;
      rd_q    <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= accept ? 4'd0 : (state == WAIT) ? cnt + 4'd1 : cnt;
      if (accept) begin
        we_q    <= i_wb_we;
        addr_q  <= i_wb_addr;
        wdata_q <= i_wb_data;
        sel_q   <= i_wb_sel;
      end
      if (state_nx == RESP)
        rd_q <= mem[rd_idx];
    end
  end
  always_ff @(posedge clk) begin
    if (o_wb_ack && we_q)
      for (int b = 0; b < 4; b++)
        if (sel_q[b])
          mem[addr_q[AW+1:2]][8*b +: 8] <= wdata_q[8*b +: 8];
  end
endmodule

// File: tb/tb_wb_ram_responder.sv
// tb_wb_ram_responder: directed checks of a zero-wait (u0) and a three-wait (u1) responder.
module tb_wb_ram_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  cyc = '0, stb = '0, we = '0, ack, err, stall;
  logic [31:0] adr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic [3:0]  sel [2];
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  wb_ram_responder #(.WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
    .i_wb_addr(adr[0]), .i_wb_data(wdat[0]), .i_wb_sel(sel[0]),
    .o_wb_data(rdat[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0]), .o_wb_stall(stall[0]));
  wb_ram_responder #(.WAIT_STATES(3)) u1 (
    .clk(clk), .reset(reset), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
    .i_wb_addr(adr[1]), .i_wb_data(wdat[1]), .i_wb_sel(sel[1]),
    .o_wb_data(rdat[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1]), .o_wb_stall(stall[1]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input int d, input logic w, input logic [31:0] a, input logic [31:0] dt,
                       input logic [3:0] s);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = dt; sel[d] = s;
  endtask
  task automatic req(input int d, input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] dt, input logic [3:0] s, input logic ok,
                     input logic [31:0] exp_data);
    int lat = 0;
    bit got = 0;
    @(negedge clk);
    drive(d, w, a, dt, s);
    chk({tag, "_stall_idle"}, 32'(stall[d]), 32'd0);
    @(posedge clk); #1 stb[d] = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = ack[d] | err[d];
    end
    chk({tag, "_latency"}, lat, (d == 0) ? 1 : 4);
    chk({tag, "_ack"}, 32'(ack[d]), 32'(ok));
    chk({tag, "_err"}, 32'(err[d]), 32'(!ok));
    chk({tag, "_data"}, rdat[d], exp_data);
    chk({tag, "_stall_busy"}, 32'(stall[d]), 32'd1);
    @(posedge clk); #1 cyc[d] = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      adr[i] = '0; wdat[i] = '0; sel[i] = '0;
    end
    // reset held with a request presented
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'hb000_0010;
    repeat (3) @(negedge clk);
    chk("rst_outs", {rdat[0][29:0], ack[0], err[0]}, 32'd0);
    chk("rst_stall", 32'(stall[0]), 32'd0);
    cyc = '0; stb = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_outs", {rdat[0][28:0], ack[0], err[0], stall[0]}, 32'd0);
    // zero wait states
    req(0, "w_beef", 1'b1, 32'hb000_0010, 32'hdeadbeef, 4'hf, 1'b1, 32'd0);
    req(0, "r_beef", 1'b0, 32'hb000_0010, 32'd0, 4'hf, 1'b1, 32'hdeadbeef);
    // byte enables
    req(0, "w_base", 1'b1, 32'hb000_0020, 32'h11223344, 4'hf, 1'b1, 32'd0);
    req(0, "w_sel5", 1'b1, 32'hb000_0020, 32'haabbccdd, 4'b0101, 1'b1, 32'd0);
    req(0, "r_sel5", 1'b0, 32'hb000_0020, 32'd0, 4'b0000, 1'b1, 32'h11bb33dd);
    req(0, "w_sel0", 1'b1, 32'hb000_0020, 32'hffffffff, 4'b0000, 1'b1, 32'd0);
    req(0, "r_sel0", 1'b0, 32'hb000_0020, 32'd0, 4'hf, 1'b1, 32'h11bb33dd);
    // errors
    req(0, "w_word0", 1'b1, 32'hb000_0000, 32'h55aa55aa, 4'hf, 1'b1, 32'd0);
    req(0, "r_miss", 1'b0, 32'ha000_0000, 32'd0, 4'hf, 1'b0, 32'd0);
    req(0, "r_unal", 1'b0, 32'hb000_0002, 32'd0, 4'hf, 1'b0, 32'd0);
    req(0, "w_miss", 1'b1, 32'hb001_0000, 32'h99999999, 4'hf, 1'b0, 32'd0);
    req(0, "r_word0", 1'b0, 32'hb000_0000, 32'd0, 4'hf, 1'b1, 32'h55aa55aa);
    // three wait states with stb held for back-to-back requests
    req(1, "w_fffc", 1'b1, 32'hb000_fffc, 32'h0000cafe, 4'hf, 1'b1, 32'd0);
    @(negedge clk);
    drive(1, 1'b0, 32'hb000_fffc, 32'd0, 4'hf);
    chk("b2b_stall_n", 32'(stall[1]), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_stall_n%0d", k), 32'(stall[1]), (k >= 1 && k <= 4) || k == 6);
      chk($sformatf("b2b_ack_n%0d", k), 32'(ack[1]), 32'(k == 4));
      if (k == 4) chk("b2b_data", rdat[1], 32'h0000cafe);
    end
    stb[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_ack2", 32'(ack[1]), 32'd1);
    @(posedge clk); #1 cyc[1] = 1'b0;
    // abort by dropping cyc
    req(1, "w_old", 1'b1, 32'hb000_0040, 32'h0badf00d, 4'hf, 1'b1, 32'd0);
    @(negedge clk);
    drive(1, 1'b1, 32'hb000_0040, 32'h12345678, 4'hf);
    @(posedge clk); #1 stb[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cyc[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("abort_resp%0d", k), {30'd0, ack[1], err[1]}, 32'd0);
    end
    chk("abort_idle", 32'(stall[1]), 32'd0);
    req(1, "r_abort", 1'b0, 32'hb000_0040, 32'd0, 4'hf, 1'b1, 32'h0badf00d);
    // abort by reset
    @(negedge clk);
    drive(1, 1'b1, 32'hb000_0040, 32'h12345678, 4'hf);
    @(posedge clk); #1 stb[1] = 1'b0;
    @(negedge clk);
    chk("rstab_busy", 32'(stall[1]), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstab_now", {rdat[1][28:0], ack[1], err[1], stall[1]}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rstab_resp%0d", k), {30'd0, ack[1], err[1]}, 32'd0);
    end
    cyc[1] = 1'b0;
    reset = 1'b1;
    req(1, "r_rstab", 1'b0, 32'hb000_0040, 32'd0, 4'hf, 1'b1, 32'h0badf00d);
    req(0, "r_keep", 1'b0, 32'hb000_0010, 32'd0, 4'hf, 1'b1, 32'hdeadbeef);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
